// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: iterative N x N -> 2N multiplier, one shift-add step per clock.
// A single nbit-wide ripple-carry adder (cin = 0) accumulates the multiplicand into
// the upper half of the P shift register, which also holds the remaining multiplier bits.
//
// Optional build macro: SHIFT_ADD_SIGNED_EN (two's-complement operands; the magnitudes are
// multiplied and the 2N-bit result is negated on completion when the operand signs differ).
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset
//   start   - operation request, sampled only in IDLE
//   a, b    - multiplicand / multiplier, sampled with start
//   busy    - high while iterating (CALC)
//   done    - one-cycle pulse, product just updated
//   product - registered 2N-bit result, held until the next completion
module shift_add_multiplier #(
    parameter int unsigned nbit = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [nbit-1:0]   a,
    input  logic [nbit-1:0]   b,
    output logic              busy,
    output logic              done,
    output logic [2*nbit-1:0] product
);
    localparam int unsigned PW = 2 * nbit;
    localparam int unsigned CW = $clog2(nbit + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nx;
    logic [nbit-1:0] m, m_nx;
    logic [PW-1:0]   p, p_nx;
    logic [CW-1:0]   cnt, cnt_nx;
    logic [PW-1:0]   product_nx;
    logic            busy_nx, done_nx;

    logic [nbit-1:0] add_x, add_y, add_s;
    logic            add_cout;
    logic [PW-1:0]   p_shift;
    logic [nbit-1:0] a_op, b_op;
    logic [PW-1:0]   result;

`ifdef SHIFT_ADD_SIGNED_EN
    logic sign, sign_nx;

    // Operand magnitudes; the most negative value maps to 2^(nbit-1), still exact unsigned.
    assign a_op   = a[nbit-1] ? (~a + nbit'(1)) : a;
    assign b_op   = b[nbit-1] ? (~b + nbit'(1)) : b;
    assign result = sign ? (~p_shift + PW'(1)) : p_shift;
`else
    assign a_op   = a;
    assign b_op   = b;
    assign result = p_shift;
`endif

    // Ripple-carry adder: upper half of P plus multiplicand gated by the current multiplier bit.
    assign add_x = p[PW-1:nbit];
    assign add_y = p[0] ? m : '0;

    always_comb begin
        logic c;
        c     = 1'b0;
        add_s = '0;
        for (int i = 0; i < int'(nbit); i++) begin
            add_s[i] = add_x[i] ^ add_y[i] ^ c;
            c        = (add_x[i] & add_y[i]) | (c & (add_x[i] ^ add_y[i]));
        end
        add_cout = c;
    end

    // Logical right shift folding the adder carry into the top bit.
    assign p_shift = {add_cout, add_s, p[nbit-1:1]};

    // Next-state and datapath control.
    always_comb begin
        state_nx   = state;
        m_nx       = m;
        p_nx       = p;
        cnt_nx     = cnt;
        product_nx = product;
`ifdef SHIFT_ADD_SIGNED_EN
        sign_nx    = sign;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    m_nx     = a_op;
                    p_nx     = {{nbit{1'b0}}, b_op};
                    cnt_nx   = CW'(nbit);
`ifdef SHIFT_ADD_SIGNED_EN
                    sign_nx  = a[nbit-1] ^ b[nbit-1];
`endif
                    state_nx = CALC;
                end
            end
            CALC: begin
                p_nx   = p_shift;
                cnt_nx = cnt - CW'(1);
                if (cnt == CW'(1)) begin
                    product_nx = result;
                    state_nx   = DONE;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        busy_nx = (state_nx == CALC);
        done_nx = (state_nx == DONE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m       <= '0;
            p       <= '0;
            cnt     <= '0;
            product <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef SHIFT_ADD_SIGNED_EN
            sign    <= 1'b0;
`endif
        end else begin
            state   <= state_nx;
            m       <= m_nx;
            p       <= p_nx;
            cnt     <= cnt_nx;
            product <= product_nx;
            busy    <= busy_nx;
            done    <= done_nx;
`ifdef SHIFT_ADD_SIGNED_EN
            sign    <= sign_nx;
`endif
        end
    end

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Testbench for shift_add_multiplier: nbit=8 and nbit=32 instances, randomized and directed
// operations, expected results queued at issue time and checked by an independent monitor.
module tb_shift_add_multiplier;
    localparam int unsigned N8  = 8;
    localparam int unsigned N32 = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8;
    logic [15:0] prod8;

    logic        start32 = 1'b0;
    logic [31:0] a32 = '0, b32 = '0;
    logic        busy32, done32;
    logic [63:0] prod32;

    shift_add_multiplier #(.nbit(N8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .product(prod8)
    );

    shift_add_multiplier #(.nbit(N32)) u_dut32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .product(prod32)
    );

    typedef struct {
        int              id;     // 0 = 8-bit instance, 1 = 32-bit instance
        longint unsigned prod;
        int unsigned     cyc;    // edge count after which done must be seen
    } exp_t;

    exp_t            sb[$];
    longint unsigned last8 = 0, last32 = 0;
    int unsigned     cyc = 0;
    int              tests = 0, fails = 0;

    // Reference: plain integer multiply, optionally on sign-extended operands.
    function automatic longint unsigned model(input longint unsigned x, input longint unsigned y,
                                              input int n);
        longint unsigned mask, r;
        mask = (2 * n >= 64) ? ~64'd0 : ((64'd1 << (2 * n)) - 64'd1);
`ifdef SHIFT_ADD_SIGNED_EN
        begin
            longint sx, sy;
            sx = longint'(x) - (((x >> (n - 1)) & 64'd1) != 0 ? (longint'(1) << n) : longint'(0));
            sy = longint'(y) - (((y >> (n - 1)) & 64'd1) != 0 ? (longint'(1) << n) : longint'(0));
            r  = longint unsigned'(sx * sy);
        end
`else
        r = x * y;
`endif
        return r & mask;
    endfunction

    task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h (edge %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int k, input int unsigned n, input logic dn, input logic bs,
                       input longint unsigned pr);
        logic has;
        exp_t e;
        has = (sb.size() > 0) && (sb[0].id == k);
        if (has && cyc > sb[0].cyc && !dn) begin
            tests++; fails++;
            $display("FAIL done_missing[%0d]: no done by edge %0d required at %0d", k, cyc, sb[0].cyc);
            void'(sb.pop_front());
            has = (sb.size() > 0) && (sb[0].id == k);
        end
        if (dn) begin
            if (!has) begin
                tests++; fails++;
                $display("FAIL done_unexpected[%0d]: done=1 required 0 at edge %0d", k, cyc);
            end else begin
                e = sb.pop_front();
                check($sformatf("product[%0d]", k), pr, e.prod);
                check($sformatf("done_edge[%0d]", k), 64'(cyc), 64'(e.cyc));
                if (k == 0) last8 = e.prod; else last32 = e.prod;
            end
            check($sformatf("busy_in_done[%0d]", k), 64'(bs), 64'd0);
        end else begin
            check($sformatf("product_hold[%0d]", k), pr, (k == 0) ? last8 : last32);
            check($sformatf("busy[%0d]", k), 64'(bs),
                  64'(has && (cyc + n >= sb[0].cyc) && (cyc < sb[0].cyc)));
        end
    endtask

    // Monitor: samples 1 time unit after every rising edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst_n) begin
                mon(0, N8, done8, busy8, 64'(prod8));
                mon(1, N32, done32, busy32, prod32);
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (!busy8 && !done8 && !busy32 && !done32) return;
        end
        tests++; fails++;
        $display("FAIL wait_idle: DUT never returned to idle");
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0) return;
        end
        tests++; fails++;
        $display("FAIL drain: %0d results never appeared", sb.size());
        sb.delete();
    endtask

    task automatic op8(input logic [7:0] x, input logic [7:0] y);
        exp_t e;
        wait_idle();
        a8 = x; b8 = y; start8 = 1'b1;
        e.id = 0; e.prod = model(64'(x), 64'(y), N8); e.cyc = cyc + 1 + N8;
        sb.push_back(e);
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic op32(input logic [31:0] x, input logic [31:0] y);
        exp_t e;
        wait_idle();
        a32 = x; b32 = y; start32 = 1'b1;
        e.id = 1; e.prod = model(64'(x), 64'(y), N32); e.cyc = cyc + 1 + N32;
        sb.push_back(e);
        @(posedge clk); #1;
        start32 = 1'b0;
    endtask

    initial begin
        exp_t e;
        int unsigned e0;

        // Reset state, no clock required.
        #1;
        check("reset_busy8", 64'(busy8), 64'd0);
        check("reset_done8", 64'(done8), 64'd0);
        check("reset_prod8", 64'(prod8), 64'd0);
        check("reset_prod32", prod32, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed unsigned cases.
        op8(8'd13, 8'd11);
        op8(8'd255, 8'd255);
        op8(8'd0, 8'd200);
        op8(8'd1, 8'd1);
        drain();

        // Randomized 8-bit operations.
        for (int i = 0; i < 24; i++) op8(8'($urandom), 8'($urandom));
        drain();

        // start held high with operands changed mid-CALC.
        wait_idle();
        a8 = 8'd57; b8 = 8'd201; start8 = 1'b1;
        e0 = cyc + 1;
        e.id = 0; e.prod = model(64'd57, 64'd201, N8); e.cyc = e0 + N8;
        sb.push_back(e);
        e.prod = model(64'd99, 64'd143, N8); e.cyc = e0 + 2 * N8 + 2;
        sb.push_back(e);
        repeat (3) @(posedge clk);
        #1;
        a8 = 8'd99; b8 = 8'd143;
        for (int i = 0; i < 40 && cyc < e0 + N8 + 2; i++) begin
            @(posedge clk); #1;
        end
        start8 = 1'b0;
        drain();

        // 32-bit instance.
        op32(32'hFFFF_FFFF, 32'd2);
        op32(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        for (int i = 0; i < 4; i++) op32($urandom, $urandom);
        drain();

`ifdef SHIFT_ADD_SIGNED_EN
        op8(8'hFD, 8'd7);
        op8(8'h80, 8'h80);
        op8(8'h80, 8'd1);
        op32(32'h8000_0000, 32'h8000_0000);
        drain();
`endif

        // Asynchronous reset between edges in the middle of an operation.
        wait_idle();
        a8 = 8'd200; b8 = 8'd100; start8 = 1'b1;
        e.id = 0; e.prod = model(64'd200, 64'd100, N8); e.cyc = cyc + 1 + N8;
        sb.push_back(e);
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("midreset_busy8", 64'(busy8), 64'd0);
        check("midreset_done8", 64'(done8), 64'd0);
        check("midreset_prod8", 64'(prod8), 64'd0);
        sb.delete();
        last8 = 0; last32 = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        op8(8'd3, 8'd5);
        drain();

        repeat (3) @(posedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
